// File: rtl/aes_tcdm_responder.sv
// Word-interleaved multi-bank TCDM responder with per-bank round-robin arbitration and 1-cycle responses.
// Optional random grant stalling is compiled in with `define AES_TCDM_STALL_EN.
module aes_tcdm_responder #(
   parameter int unsigned MP         = 2,
   parameter int unsigned NB_BANKS   = 4,
   parameter int unsigned BANK_WORDS = 256,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [MP-1:0]            tcdm_req_i,
   output logic [MP-1:0]            tcdm_gnt_o,
   input  logic [MP*32-1:0]         tcdm_add_i,
   input  logic [MP-1:0]            tcdm_wen_i,
   input  logic [MP*DATA_W/8-1:0]   tcdm_be_i,
   input  logic [MP*DATA_W-1:0]     tcdm_data_i,
   output logic [MP*DATA_W-1:0]     tcdm_r_data_o,
   output logic [MP-1:0]            tcdm_r_valid_o
);

   // Handshake: a request is accepted in the cycle where req and gnt are both high; the
   // master holds all request fields until then. Every acceptance yields r_valid exactly
   // one cycle later (reads carry the word, writes carry zero); r_valid has no ready.

   localparam int unsigned NB_BE    = DATA_W / 8;
   localparam int unsigned BANK_LOG = $clog2(NB_BANKS);
   localparam int unsigned BANK_W   = (BANK_LOG > 0) ? BANK_LOG : 1;
   localparam int unsigned ROW_W    = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
   localparam int unsigned RR_W     = (MP > 1) ? $clog2(MP) : 1;

   logic [MP-1:0][29:0]           word_idx;
   logic [MP-1:0][BANK_W-1:0]     bank_sel;
   logic [MP-1:0][ROW_W-1:0]      row_sel;
   logic [MP-1:0][1:0]            unused_add_lsb;

   logic [NB_BANKS-1:0][RR_W-1:0] rr_q;
   logic [NB_BANKS-1:0][RR_W-1:0] win;
   logic [NB_BANKS-1:0]           bank_hit;
   logic                          stall;
   logic                          grant_en;

   logic [DATA_W-1:0]             mem_q [NB_BANKS][BANK_WORDS];

   // Out-of-range addresses wrap: only the low bank/row bits of the word index survive.
   always_comb begin
      word_idx       = '0;
      bank_sel       = '0;
      row_sel        = '0;
      unused_add_lsb = '0;
      for (int p = 0; p < MP; p++) begin
         word_idx[p]       = tcdm_add_i[p*32+2 +: 30];
         bank_sel[p]       = BANK_W'(word_idx[p] & 30'(NB_BANKS - 1));
         row_sel[p]        = ROW_W'((word_idx[p] >> BANK_LOG) & 30'(BANK_WORDS - 1));
         unused_add_lsb[p] = tcdm_add_i[p*32 +: 2];
      end
   end

`ifdef AES_TCDM_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign grant_en = !rst_i && !stall;

   // Per bank: first requester at or after the rr pointer, wrapping around.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      bank_hit   = '0;
      win        = '0;
      tcdm_gnt_o = '0;
      for (int b = 0; b < NB_BANKS; b++) begin
         for (int k = 0; k < MP; k++) begin
            idx = (int'(rr_q[b]) + k) % MP;
            if (!bank_hit[b] && tcdm_req_i[idx] && (bank_sel[idx] == BANK_W'(b))) begin
               bank_hit[b] = 1'b1;
               win[b]      = RR_W'(idx);
            end
         end
         if (grant_en && bank_hit[b]) begin
            tcdm_gnt_o[win[b]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q <= '0;
      end else if (!stall) begin
         for (int b = 0; b < NB_BANKS; b++) begin
            if (bank_hit[b]) begin
               rr_q[b] <= RR_W'((int'(win[b]) + 1) % MP);
            end
         end
      end
   end

   // Storage is deliberately not reset so contents survive rst_i.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB_BANKS; b++) begin
         if (grant_en && bank_hit[b] && !tcdm_wen_i[win[b]]) begin
            for (int i = 0; i < NB_BE; i++) begin
               if (tcdm_be_i[win[b]*NB_BE + i]) begin
                  mem_q[b][row_sel[win[b]]][8*i +: 8] <= tcdm_data_i[win[b]*DATA_W + 8*i +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tcdm_r_valid_o <= '0;
         tcdm_r_data_o  <= '0;
      end else begin
         for (int p = 0; p < MP; p++) begin
            tcdm_r_valid_o[p] <= tcdm_gnt_o[p];
            if (tcdm_gnt_o[p] && tcdm_wen_i[p]) begin
               tcdm_r_data_o[p*DATA_W +: DATA_W] <= mem_q[bank_sel[p]][row_sel[p]];
            end else begin
               tcdm_r_data_o[p*DATA_W +: DATA_W] <= '0;
            end
         end
      end
   end

endmodule
